// File: rtl/ioctl_arb_pkg.sv
// ioctl_arb_pkg: shared types and widths for the download/CPU memory arbiter.
package ioctl_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, DL, CPU} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wentry_t;

endpackage

// File: rtl/ioctl_wfifo.sv
// ioctl_wfifo: show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module ioctl_wfifo #(
    parameter int AW = 2,
    parameter int W  = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          drop
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  buf_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          wr_en, rd_en;

    always_comb begin
        full  = lvl_q[AW];
        empty = lvl_q == '0;
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        drop  = push && !wr_en;
        wp_d  = wr_en ? wp_q + AW'(1) : wp_q;
        rp_d  = rd_en ? rp_q + AW'(1) : rp_q;
        lvl_d = (wr_en && !rd_en) ? lvl_q + (AW+1)'(1) :
                (rd_en && !wr_en) ? lvl_q - (AW+1)'(1) : lvl_q;
        dout  = buf_q[rp_q];
        level = lvl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wp_q] <= din;
    end

endmodule

// File: rtl/ioctl_mem_arbiter.sv
// ioctl_mem_arbiter: shares one memory port between a buffered download write stream and the CPU bus,
// round-robin on ties with the download side forced ahead once the FIFO reaches HIWAT.
module ioctl_mem_arbiter
    import ioctl_arb_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int HIWAT   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    input  logic              downloading,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ack,
    output logic              fifo_ovf
);

    localparam logic [FIFO_AW:0] HI = (FIFO_AW+1)'(HIWAT);

    state_e            state_q, state_d;
    logic              turn_q, turn_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              ovf_q, ovf_d;

    wentry_t           head;
    logic              pop, fifo_full, fifo_empty, fifo_drop;
    logic [FIFO_AW:0]  fifo_level;
    logic              cpu_pend, grant_dl;

    ioctl_wfifo #(
        .AW (FIFO_AW),
        .W  ($bits(wentry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dl_wr),
        .pop   (pop),
        .din   ({dl_addr, dl_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cpu_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        pop        = 1'b0;
        ovf_d      = ovf_q | fifo_drop;
        // cpu_ack_q masks the request the CPU has not yet had a chance to drop
        cpu_pend   = cpu_req && !cpu_ack_q;
        grant_dl   = !fifo_empty && (!cpu_pend || fifo_level >= HI || !turn_q);
        case (state_q)
            IDLE: begin
                if (grant_dl) begin
                    state_d    = DL;
                    turn_d     = 1'b1;
                    pop        = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = head.addr;
                    mem_din_d  = head.data;
                end else if (cpu_pend) begin
                    state_d    = CPU;
                    turn_d     = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = cpu_we;
                    mem_addr_d = cpu_addr;
                    mem_din_d  = cpu_din;
                end
            end
            DL: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            CPU: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    cpu_ack_d  = 1'b1;
                    cpu_dout_d = cpu_we ? cpu_dout_q : mem_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            turn_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_dout_q <= cpu_dout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign fifo_ovf = ovf_q;
    assign cpu_wait = downloading | !fifo_empty;

endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// tb_ioctl_mem_arbiter: directed scenarios for the download/CPU memory arbiter.
module tb_ioctl_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, dl_wr, downloading, cpu_req, cpu_we, mem_ack;
    logic [24:0] dl_addr, cpu_addr, mem_addr;
    logic [7:0]  dl_data, cpu_din, cpu_dout, mem_din, mem_dout;
    logic        cpu_ack, cpu_wait, mem_req, mem_we, fifo_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ioctl_mem_arbiter #(.FIFO_AW(2), .HIWAT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .downloading (downloading),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .cpu_wait    (cpu_wait),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_ack     (mem_ack),
        .fifo_ovf    (fifo_ovf)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        downloading = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_din = '0;
        mem_ack = 1'b0;
        mem_dout = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic push(input logic [24:0] a, input logic [7:0] d);
        dl_wr = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick;
        dl_wr = 1'b0;
    endtask

    // Memory responder: waits for a request, checks it, acks one cycle later.
    task automatic serve(input string nm, input logic we, input logic [24:0] a,
                         input logic [7:0] d, input logic [7:0] rd, input logic is_cpu);
        int t = 0;
        while (!mem_req && t < 20) begin
            tick;
            t++;
        end
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_timeout: got %b want 1", nm, mem_req);
        end
        n_cmp++;
        if ({mem_we, mem_addr, mem_din} !== {we, a, d}) begin
            n_err++;
            $display("FAIL %s access: got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                     nm, mem_we, mem_addr, mem_din, we, a, d);
        end
        tick;
        mem_ack = 1'b1;
        mem_dout = rd;
        tick;
        mem_ack = 1'b0;
        mem_dout = '0;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s req_drop: got %b want 0", nm, mem_req);
        end
        if (is_cpu) begin
            n_cmp++;
            if (cpu_ack !== 1'b1 || (!we && cpu_dout !== rd)) begin
                n_err++;
                $display("FAIL %s cpu_done: got ack=%b dout=%h want ack=1 dout=%h", nm, cpu_ack, cpu_dout, rd);
            end
            cpu_req = 1'b0;
            tick;
            n_cmp++;
            if (cpu_ack !== 1'b0) begin
                n_err++;
                $display("FAIL %s ack_pulse: got %b want 0", nm, cpu_ack);
            end
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_din, cpu_ack, cpu_dout, cpu_wait, fifo_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h din=%h ack=%b dout=%h wait=%b ovf=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_din, cpu_ack, cpu_dout, cpu_wait, fifo_ovf);
        end
        downloading = 1'b1;
        #1;
        n_cmp++;
        if (cpu_wait !== 1'b1) begin
            n_err++;
            $display("FAIL wait_downloading: got %b want 1", cpu_wait);
        end
        downloading = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        tick;
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack_ignored: got req=%b ack=%b want 0 0", mem_req, cpu_ack);
        end
    endtask

    task automatic test_single_dl;
        do_reset;
        push(25'h000100, 8'hA5);
        n_cmp++;
        if (cpu_wait !== 1'b1 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL dl_pushed: got wait=%b req=%b want 1 0", cpu_wait, mem_req);
        end
        tick;
        n_cmp++;
        if (cpu_wait !== 1'b0 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL dl_granted: got wait=%b req=%b want 0 1", cpu_wait, mem_req);
        end
        serve("single_dl", 1'b1, 25'h000100, 8'hA5, 8'h00, 1'b0);
    endtask

    task automatic test_cpu_read;
        do_reset;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 25'h080010;
        cpu_din = 8'h00;
        serve("cpu_read", 1'b0, 25'h080010, 8'h00, 8'h3C, 1'b1);
    endtask

    task automatic test_contention;
        do_reset;
        push(25'h000200, 8'h11);
        dl_wr = 1'b1;
        dl_addr = 25'h000201;
        dl_data = 8'h22;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 25'h0AAAAA;
        cpu_din = 8'h77;
        tick;
        dl_wr = 1'b0;
        serve("ct_dl1", 1'b1, 25'h000200, 8'h11, 8'h00, 1'b0);
        serve("ct_cpu", 1'b1, 25'h0AAAAA, 8'h77, 8'h00, 1'b1);
        serve("ct_dl2", 1'b1, 25'h000201, 8'h22, 8'h00, 1'b0);
    endtask

    task automatic test_hiwat;
        do_reset;
        push(25'h000300, 8'h31);
        push(25'h000301, 8'h32);
        push(25'h000302, 8'h33);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 25'h000001;
        cpu_din = 8'h55;
        push(25'h000303, 8'h34);
        serve("hw_dl1", 1'b1, 25'h000300, 8'h31, 8'h00, 1'b0);
        serve("hw_dl2", 1'b1, 25'h000301, 8'h32, 8'h00, 1'b0);
        serve("hw_cpu", 1'b1, 25'h000001, 8'h55, 8'h00, 1'b1);
        serve("hw_dl3", 1'b1, 25'h000302, 8'h33, 8'h00, 1'b0);
        serve("hw_dl4", 1'b1, 25'h000303, 8'h34, 8'h00, 1'b0);
    endtask

    task automatic test_overflow;
        do_reset;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 25'h000123;
        cpu_din = 8'h00;
        tick;
        for (int i = 0; i < 5; i++) begin
            push(25'h000400 + 25'(i), 8'hB0 + 8'(i));
            if (i == 3) begin
                n_cmp++;
                if (fifo_ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_at_full: got %b want 0", fifo_ovf);
                end
            end
        end
        n_cmp++;
        if (fifo_ovf !== 1'b1 || cpu_wait !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b wait=%b want 1 1", fifo_ovf, cpu_wait);
        end
        serve("ov_cpu", 1'b0, 25'h000123, 8'h00, 8'h99, 1'b1);
        for (int i = 0; i < 4; i++)
            serve("ov_dl", 1'b1, 25'h000400 + 25'(i), 8'hB0 + 8'(i), 8'h00, 1'b0);
        tick;
        tick;
        n_cmp++;
        if (mem_req !== 1'b0 || fifo_ovf !== 1'b1 || cpu_wait !== 1'b0) begin
            n_err++;
            $display("FAIL ov_drained: got req=%b ovf=%b wait=%b want 0 1 0", mem_req, fifo_ovf, cpu_wait);
        end
    endtask

    task automatic test_full_pushpop;
        do_reset;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 25'h000555;
        cpu_din = 8'h66;
        tick;
        for (int i = 0; i < 4; i++) push(25'h000500 + 25'(i), 8'hC0 + 8'(i));
        tick;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        n_cmp++;
        if (cpu_ack !== 1'b1) begin
            n_err++;
            $display("FAIL fp_cpu_ack: got %b want 1", cpu_ack);
        end
        cpu_req = 1'b0;
        push(25'h000504, 8'hC4);
        n_cmp++;
        if (fifo_ovf !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 25'h000500) begin
            n_err++;
            $display("FAIL fp_same_cycle: got ovf=%b req=%b addr=%h want 0 1 000500", fifo_ovf, mem_req, mem_addr);
        end
        push(25'h0005FF, 8'hEE);
        n_cmp++;
        if (fifo_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL fp_still_full: got ovf=%b want 1", fifo_ovf);
        end
        for (int i = 0; i < 5; i++)
            serve("fp_dl", 1'b1, 25'h000500 + 25'(i), 8'hC0 + 8'(i), 8'h00, 1'b0);
        tick;
        tick;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL fp_drop_gone: got req=%b want 0", mem_req);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 25'h000777;
        tick;
        push(25'h000600, 8'h12);
        n_cmp++;
        if (mem_req !== 1'b1 || cpu_wait !== 1'b1) begin
            n_err++;
            $display("FAIL rm_busy: got req=%b wait=%b want 1 1", mem_req, cpu_wait);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        tick;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_din, cpu_ack, cpu_dout, cpu_wait, fifo_ovf} !== '0) begin
            n_err++;
            $display("FAIL rm_outputs: got req=%b we=%b addr=%h din=%h ack=%b dout=%h wait=%b ovf=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_din, cpu_ack, cpu_dout, cpu_wait, fifo_ovf);
        end
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_dout = 8'hAB;
        tick;
        mem_ack = 1'b0;
        mem_dout = '0;
        n_cmp++;
        if (cpu_ack !== 1'b0 || cpu_dout !== 8'h00 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rm_stale_ack: got ack=%b dout=%h req=%b want 0 00 0", cpu_ack, cpu_dout, mem_req);
        end
        tick;
        tick;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rm_fifo_empty: got req=%b want 0", mem_req);
        end
    endtask

    initial begin
        test_reset;
        test_single_dl;
        test_cpu_read;
        test_contention;
        test_hiwat;
        test_overflow;
        test_full_pushpop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
